// File: rtl/hex_fmt_pkg.sv
// Shared types and character constants for the hex-to-ASCII serializer.
// ms_nibble locates the leading non-zero nibble used for zero suppression.
package hex_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    TERM0 = 3'd4,
    TERM1 = 3'd5
  } state_e;

  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_X    = 8'h78;

  localparam int TERM_NONE  = 0;
  localparam int TERM_CRLF  = 1;
  localparam int TERM_SPACE = 2;

  // Index of the most-significant non-zero nibble; 0 when the word is zero.
  function automatic logic [3:0] ms_nibble(input logic [63:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (v[i*4 +: 4] != 4'h0) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_char_lut.sv
// Combinational nibble to ASCII hex digit.
module hex_char_lut #(
  parameter int UPPERCASE = 1
) (
  input  logic [3:0] nib,
  output logic [7:0] ch
);

  always_comb begin
    if (nib < 4'd10) ch = 8'h30 + {4'h0, nib};
    else             ch = ((UPPERCASE != 0) ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  end

endmodule

// File: rtl/hex_ascii_serializer.sv
// Serialises one WIDTH-bit word as ASCII hex characters over a valid/ready
// byte stream, with optional "0x" prefix, zero suppression and terminator.
module hex_ascii_serializer
  import hex_fmt_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int UPPERCASE      = 1,
  parameter int PREFIX_EN      = 0,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int TERM_MODE      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NIBS = WIDTH / 4;
  localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       char_q, char_d;
  logic             vld_q, vld_d;

  logic             xfer, accept, load;
  logic [IW-1:0]    start_idx;
  logic [WIDTH-1:0] nib_src;
  logic [3:0]       nib;
  logic [7:0]       digit_ch;

  assign xfer      = vld_q && out_ready;
  assign accept    = (state_q == IDLE) && in_valid;
  assign load      = accept || xfer;
  assign start_idx = (SUPPRESS_ZEROS != 0) ? IW'(ms_nibble(64'(in_data))) : IW'(NIBS - 1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        idx_d   = start_idx;
        state_d = (PREFIX_EN != 0) ? PFX0 : DIGIT;
      end
      PFX0: if (xfer) state_d = PFX1;
      PFX1: if (xfer) state_d = DIGIT;
      DIGIT: if (xfer) begin
        if (idx_q == '0) state_d = (TERM_MODE != TERM_NONE) ? TERM0 : IDLE;
        else             idx_d   = idx_q - 1'b1;
      end
      TERM0: if (xfer) state_d = (TERM_MODE == TERM_CRLF) ? TERM1 : IDLE;
      TERM1: if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On acceptance the first digit comes straight from in_data so that the
  // character is ready the cycle after the handshake.
  assign nib_src = (state_q == IDLE) ? in_data : data_q;
  assign nib     = 4'(nib_src >> {idx_d, 2'b00});

  hex_char_lut #(.UPPERCASE(UPPERCASE)) u_lut (
    .nib (nib),
    .ch  (digit_ch)
  );

  always_comb begin
    char_d = char_q;
    if (load) begin
      case (state_d)
        PFX0:    char_d = CH_ZERO;
        PFX1:    char_d = CH_X;
        DIGIT:   char_d = digit_ch;
        TERM0:   char_d = (TERM_MODE == TERM_SPACE) ? CH_SP : CH_CR;
        TERM1:   char_d = CH_LF;
        default: char_d = char_q;
      endcase
    end
    vld_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_char  = char_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_hex_ascii_serializer.sv
// Three differently configured serializers checked against a string-level
// model of the expected character stream, plus literal pins for known words.
module tb_hex_ascii_serializer;

  localparam int NI = 3;

  // cfg 0: defaults; cfg 1: 8-bit, lowercase, prefix, space; cfg 2: suppress, no term
  function automatic int cw(int k); return (k == 1) ? 8 : 16; endfunction
  function automatic int cu(int k); return (k == 1) ? 0 : 1;  endfunction
  function automatic int cp(int k); return (k == 1) ? 1 : 0;  endfunction
  function automatic int cs(int k); return (k == 2) ? 1 : 0;  endfunction
  function automatic int ct(int k); return (k == 0) ? 1 : ((k == 1) ? 2 : 0); endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_data   [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [7:0]  out_char  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        busy      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hex_ascii_serializer #(
      .WIDTH(cw(g)), .UPPERCASE(cu(g)), .PREFIX_EN(cp(g)),
      .SUPPRESS_ZEROS(cs(g)), .TERM_MODE(ct(g))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[g][cw(g)-1:0]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .out_char  (out_char[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .busy      (busy[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_buf [NI][24];
  int          exp_len [NI];
  int          exp_ptr [NI];
  logic [63:0] rec     [NI];
  int          rec_n   [NI];
  int          t_first [NI];
  int          t_last  [NI];
  bit          prev_stall [NI];
  logic [7:0]  prev_char  [NI];
  bit          rdy_rand   [NI];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexch(int k, int d);
    if (d < 10) return 8'(48 + d);
    return 8'(((cu(k) != 0) ? 65 : 97) + d - 10);
  endfunction

  // Expected characters for one word, built from the formatting rules.
  task automatic model(input int k, input logic [63:0] v);
    int n, top;
    n = 0;
    if (cp(k) != 0) begin
      exp_buf[k][n] = 8'h30; n++;
      exp_buf[k][n] = 8'h78; n++;
    end
    top = cw(k) / 4 - 1;
    if (cs(k) != 0) begin
      top = 0;
      for (int i = 0; i < cw(k) / 4; i++) if (v[i*4 +: 4] != 4'h0) top = i;
    end
    for (int i = top; i >= 0; i--) begin
      exp_buf[k][n] = hexch(k, int'(v[i*4 +: 4])); n++;
    end
    if (ct(k) == 1) begin
      exp_buf[k][n] = 8'h0D; n++;
      exp_buf[k][n] = 8'h0A; n++;
    end else if (ct(k) == 2) begin
      exp_buf[k][n] = 8'h20; n++;
    end
    exp_len[k] = n;
    exp_ptr[k] = 0;
  endtask

  task automatic monitor();
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        exp_len[k] = 0; exp_ptr[k] = 0; prev_stall[k] = 0;
        continue;
      end
      chk("busy_vs_valid", 64'(busy[k]), 64'(out_valid[k]));
      chk("ready_vs_busy", 64'(in_ready[k]), 64'(!busy[k]));
      if (prev_stall[k]) begin
        chk("stall_valid", 64'(out_valid[k]), 64'd1);
        chk("stall_char", 64'(out_char[k]), 64'(prev_char[k]));
      end
      if (out_valid[k] && out_ready[k]) begin
        if (exp_ptr[k] < exp_len[k]) begin
          chk($sformatf("char_k%0d_i%0d", k, exp_ptr[k]), 64'(out_char[k]), 64'(exp_buf[k][exp_ptr[k]]));
          exp_ptr[k]++;
        end else begin
          chk($sformatf("extra_char_k%0d", k), 64'(out_valid[k]), 64'd0);
        end
        rec[k] = {rec[k][55:0], out_char[k]};
        if (rec_n[k] == 0) t_first[k] = cyc;
        t_last[k] = cyc;
        rec_n[k]++;
      end
      if (in_valid[k] && in_ready[k]) model(k, in_data[k]);
      prev_stall[k] = out_valid[k] && !out_ready[k];
      prev_char[k]  = out_char[k];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NI; k++)
      out_ready[k] = rdy_rand[k] ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!in_ready[k] && n < 300) begin tick(); n++; end
    chk($sformatf("idle_wait_k%0d", k), 64'(in_ready[k]), 64'd1);
  endtask

  task automatic send_word(input int k, input logic [63:0] v, input bit rnd, input bit poke);
    int n;
    rdy_rand[k] = rnd;
    wait_idle(k);
    rec[k] = '0; rec_n[k] = 0;
    in_data[k] = v; in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    in_data[k]  = {$urandom, $urandom};
    if (poke) begin
      tick(); tick();
      in_valid[k] = 1'b1; in_data[k] = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) tick();
      in_valid[k] = 1'b0;
    end
    n = 0;
    while (exp_ptr[k] < exp_len[k] && n < 300) begin tick(); n++; end
    chk($sformatf("ready_after_word_k%0d", k), 64'(in_ready[k]), 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    int k;
    for (int i = 0; i < NI; i++) begin
      in_data[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      rdy_rand[i] = 1'b0; exp_len[i] = 0; exp_ptr[i] = 0;
      rec[i] = '0; rec_n[i] = 0; prev_stall[i] = 0; prev_char[i] = '0;
      t_first[i] = 0; t_last[i] = 0;
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
      chk("rst_out_char",  64'(out_char[i]),  64'd0);
      chk("rst_busy",      64'(busy[i]),      64'd0);
      chk("rst_in_ready",  64'(in_ready[i]),  64'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_word(0, 64'hBEEF, 0, 0);
    chk("beef_chars", rec[0], 64'h4245_4546_0D0A);
    chk("beef_count", 64'(rec_n[0]), 64'd6);
    chk("beef_span",  64'(t_last[0] - t_first[0]), 64'd5);

    send_word(1, 64'h3C, 0, 0);
    chk("pfx_3c_chars", rec[1], 64'h30_7833_6320);

    send_word(2, 64'h00A5, 0, 0);
    chk("sz_a5_chars", rec[2], 64'h4135);
    chk("sz_a5_count", 64'(rec_n[2]), 64'd2);
    send_word(2, 64'h0000, 0, 0);
    chk("sz_zero_chars", rec[2], 64'h30);
    chk("sz_zero_count", 64'(rec_n[2]), 64'd1);

    send_word(0, 64'h1234, 1, 1);
    chk("stall_1234_chars", rec[0], 64'h3132_3334_0D0A);

    // Reset in the middle of a word.
    rdy_rand[0] = 1'b0;
    wait_idle(0);
    rec[0] = '0; rec_n[0] = 0;
    in_data[0] = 64'h5678; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick(); tick();
    chk("pre_rst_chars", rec[0], 64'h3536);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("midrst_busy",      64'(busy[0]),      64'd0);
    tick(); tick();
    rst_n = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("post_rst_no_chars", 64'(rec_n[0]), 64'd2);
    send_word(0, 64'hBEEF, 0, 0);
    chk("post_rst_beef", rec[0], 64'h4245_4546_0D0A);

    for (int w = 0; w < 150; w++) begin
      k = $urandom_range(0, NI - 1);
      case ($urandom_range(0, 3))
        0:       v = 64'h0;
        1:       v = 64'($urandom_range(0, 255));
        default: v = {$urandom, $urandom};
      endcase
      v = v & ((64'h1 << cw(k)) - 64'h1);
      send_word(k, v, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_ascii_serializer.md
HEX_ASCII_SERIALIZER -- requirements
Module: hex_ascii_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input word width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have parameter UPPERCASE, default 1: 1 emits "A"-"F", 0 emits "a"-"f".
REQ-003 SHALL have parameter PREFIX_EN, default 0: 1 emits "0x" before the digits.
REQ-004 SHALL have parameter SUPPRESS_ZEROS, default 0: 1 skips leading zero nibbles; at least one digit is always emitted.
REQ-005 SHALL have parameter TERM_MODE, default 1: 0 emits no terminator, 1 emits CR LF (0x0D 0x0A), 2 emits one space (0x20).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port in_data, input, WIDTH bits: the value to format.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is presented.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-011 SHALL have port out_char, output, 8 bits: the current ASCII character.
REQ-012 SHALL have port out_valid, output, 1 bit: out_char is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the sink (e.g. UART TX) takes out_char.
REQ-014 SHALL have port busy, output, 1 bit: a word is being serialised.

Function
REQ-015 SHALL implement states IDLE, PFX0, PFX1, DIGIT, TERM0 and TERM1.
REQ-016 SHALL drive in_ready = 1 only in IDLE; a word is accepted when in_valid && in_ready, and in_data is latched at that edge.
REQ-017 On acceptance, SHALL enter PFX0 if PREFIX_EN, else DIGIT; out_valid rises the cycle after acceptance, giving 1-cycle latency.
REQ-018 SHALL transfer a character only on an out_valid && out_ready cycle; out_char SHALL stay stable while out_valid && !out_ready.
REQ-019 PFX0 SHALL emit "0" then go to PFX1; PFX1 SHALL emit "x" then go to DIGIT.
REQ-020 DIGIT SHALL emit nibbles MSB first, using a nibble index that counts down from WIDTH/4-1 to 0.
REQ-021 With SUPPRESS_ZEROS, the start index SHALL be the index of the most-significant non-zero nibble, computed at acceptance; a value of 0 emits a single "0".
REQ-022 After nibble 0 transfers, SHALL go to TERM0 if TERM_MODE != 0, else to IDLE.
REQ-023 TERM0 SHALL emit CR (mode 1) or space (mode 2); mode 1 SHALL continue to TERM1, which emits LF; then go to IDLE.
REQ-024 SHALL deassert out_valid in IDLE; after the final transfer, in_ready SHALL be 1 in the next cycle, and no word is accepted in the same cycle as the final transfer.
REQ-025 SHALL drive busy = !IDLE.
REQ-026 While busy, SHALL ignore in_valid and in_data.
REQ-027 If out_ready is held 1, SHALL sustain 1 character per cycle with no bubbles inside a word.

Reset
REQ-028 SHALL, on rst_n low (asynchronous), set state = IDLE, out_valid = 0, out_char = 0x00, busy = 0, nibble index = 0 and the latched word = 0; in_ready = 1 after reset.
REQ-029 A reset mid-word SHALL abandon the word with no further characters emitted.
REQ-030 Reset release SHALL be synchronous to clk.

Structure
REQ-031 Shared package hex_fmt_pkg SHALL hold the state enum, the CR/LF/space/"0"/"x" constants and the TERM_MODE encodings.
REQ-032 SHALL contain one sub-module hex_char_lut: combinational 4-bit to 8-bit ASCII, parameterised by UPPERCASE.
REQ-033 SHALL register out_char; out_char SHALL NOT be driven combinationally from in_data.

Verification
REQ-034 WIDTH=16, defaults, in_data 0xBEEF, out_ready=1 -> "B","E","E","F",0x0D,0x0A on 6 consecutive cycles, then in_ready=1.
REQ-035 WIDTH=8, UPPERCASE=0, PREFIX_EN=1, TERM_MODE=2, 0x3c -> "0","x","3","c"," ".
REQ-036 WIDTH=16, SUPPRESS_ZEROS=1, TERM_MODE=0: 0x00A5 -> "A","5"; 0x0000 -> "0".
REQ-037 Defaults, 0x1234, out_ready toggled randomly -> exact sequence "1","2","3","4",CR,LF with out_char stable during stalls; in_valid asserted mid-word -> not accepted.
REQ-038 Defaults, rst_n pulsed low after the 2nd character -> out_valid=0 immediately, in_ready=1 after release, and the next word is emitted cleanly from its first digit.
